exe_stage: RTL and testbench

Execute stage of the five-stage pipelined CPU. Consumes the ID/EX pipeline register outputs, resolves RAW operand hazards by forwarding from its own EX/MEM register and from write-back, performs the ALU/shift operation, and registers the result and control into the EX/MEM pipeline register that feeds the data-memory stage. Load-use stalls are generated upstream; this block never stalls.

---
 rtl/exe_stage.sv | 149 ++++++++++++++
 tb/tb_exe_stage.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/exe_stage.sv
// Execute stage: operand forwarding, ALU/shifter, and the EX/MEM pipeline register.
// Never stalls; load-use bubbles are inserted upstream.
module exe_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] exe_inst,
    input  logic [31:0] exe_RFRD1,
    input  logic [31:0] exe_RFRD2,
    input  logic [31:0] exe_imm32,
    input  logic [4:0]  exe_RegisterRd,
    input  logic [4:0]  exe_RegisterRs,
    input  logic [4:0]  exe_RegisterRt,
    input  logic        exe_RegDst,
    input  logic        exe_MemRead,
    input  logic        exe_MemtoReg,
    input  logic        exe_MemWrite,
    input  logic        exe_ALUSrc,
    input  logic        exe_RegWrite,
    input  logic        exe_ShiftIndex,
    input  logic        exe_ShiftDirection,
    input  logic        exe_ALUasrc,
    input  logic [3:0]  exe_ALUOp,
    input  logic        exe_flush,
    input  logic        wb_RegWrite,
    input  logic [4:0]  wb_RegisterW,
    input  logic [31:0] wb_WriteData,
    output logic [31:0] mem_ALUResult,
    output logic [31:0] mem_WriteData,
    output logic [4:0]  mem_RegisterW,
    output logic        mem_MemRead,
    output logic        mem_MemWrite,
    output logic        mem_MemtoReg,
    output logic        mem_RegWrite,
    output logic        mem_Zero,
    output logic        mem_Overflow,
    output logic [31:0] mem_inst
);

    logic [31:0] alu_q, alu_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] inst_q, inst_d;
    logic [4:0]  regw_q, regw_d;
    logic        memrd_q, memrd_d;
    logic        memwr_q, memwr_d;
    logic        m2r_q, m2r_d;
    logic        rwr_q, rwr_d;
    logic        zero_q, zero_d;
    logic        ovf_q, ovf_d;

    logic        mem_src_ok, wb_src_ok;
    logic [31:0] fwd_a, fwd_b, op_a, op_b, sum, diff, result;
    logic [4:0]  shamt;
    logic        ovf;

    // A load sitting in MEM has no data yet, so it is never a forwarding source.
    assign mem_src_ok = rwr_q && !memrd_q && (regw_q != 5'd0);
    assign wb_src_ok  = wb_RegWrite && (wb_RegisterW != 5'd0);

    always_comb begin
        fwd_a = exe_RFRD1;
        if (wb_src_ok && wb_RegisterW == exe_RegisterRs) fwd_a = wb_WriteData;
        if (mem_src_ok && regw_q == exe_RegisterRs)      fwd_a = alu_q;
        fwd_b = exe_RFRD2;
        if (wb_src_ok && wb_RegisterW == exe_RegisterRt) fwd_b = wb_WriteData;
        if (mem_src_ok && regw_q == exe_RegisterRt)      fwd_b = alu_q;
    end

    assign op_a  = exe_ALUasrc ? 32'h0 : fwd_a;
    assign op_b  = exe_ALUSrc ? exe_imm32 : fwd_b;
    assign shamt = exe_ShiftIndex ? exe_inst[10:6] : op_a[4:0];
    assign sum   = op_a + op_b;
    assign diff  = op_a - op_b;

    always_comb begin
        result = 32'h0;
        ovf    = 1'b0;
        case (exe_ALUOp)
            4'b0000: begin
                result = sum;
                ovf    = (op_a[31] == op_b[31]) && (sum[31] != op_a[31]);
            end
            4'b0001: begin
                result = diff;
                ovf    = (op_a[31] != op_b[31]) && (diff[31] != op_a[31]);
            end
            4'b0010: result = op_a & op_b;
            4'b0011: result = op_a | op_b;
            4'b0100: result = op_a ^ op_b;
            4'b0101: result = ~(op_a | op_b);
            4'b0110: result = {31'h0, $signed(op_a) < $signed(op_b)};
            4'b0111: result = {31'h0, op_a < op_b};
            4'b1000: result = exe_ShiftDirection ? (op_b >> shamt) : (op_b << shamt);
            4'b1001: result = $unsigned($signed(op_b) >>> shamt);
            4'b1010: result = {op_b[15:0], 16'h0};
            default: result = 32'h0;
        endcase
    end

    always_comb begin
        alu_d   = result;
        wdata_d = fwd_b;
        inst_d  = exe_inst;
        regw_d  = exe_RegDst ? exe_RegisterRd : exe_RegisterRt;
        zero_d  = (result == 32'h0);
        memrd_d = exe_MemRead  && !exe_flush;
        memwr_d = exe_MemWrite && !exe_flush;
        m2r_d   = exe_MemtoReg && !exe_flush;
        rwr_d   = exe_RegWrite && !exe_flush;
        ovf_d   = ovf          && !exe_flush;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            alu_q   <= 32'h0;
            wdata_q <= 32'h0;
            inst_q  <= 32'h0;
            regw_q  <= 5'h0;
            memrd_q <= 1'b0;
            memwr_q <= 1'b0;
            m2r_q   <= 1'b0;
            rwr_q   <= 1'b0;
            zero_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            alu_q   <= alu_d;
            wdata_q <= wdata_d;
            inst_q  <= inst_d;
            regw_q  <= regw_d;
            memrd_q <= memrd_d;
            memwr_q <= memwr_d;
            m2r_q   <= m2r_d;
            rwr_q   <= rwr_d;
            zero_q  <= zero_d;
            ovf_q   <= ovf_d;
        end
    end

    assign mem_ALUResult = alu_q;
    assign mem_WriteData = wdata_q;
    assign mem_inst      = inst_q;
    assign mem_RegisterW = regw_q;
    assign mem_MemRead   = memrd_q;
    assign mem_MemWrite  = memwr_q;
    assign mem_MemtoReg  = m2r_q;
    assign mem_RegWrite  = rwr_q;
    assign mem_Zero      = zero_q;
    assign mem_Overflow  = ovf_q;

endmodule

// File: tb/tb_exe_stage.sv
// Bench for exe_stage: directed scenarios followed by random instructions,
// every cycle compared against an arithmetic reference of the execute stage.
module tb_exe_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] exe_inst, exe_RFRD1, exe_RFRD2, exe_imm32;
    logic [4:0]  exe_RegisterRd, exe_RegisterRs, exe_RegisterRt;
    logic        exe_RegDst, exe_MemRead, exe_MemtoReg, exe_MemWrite, exe_ALUSrc;
    logic        exe_RegWrite, exe_ShiftIndex, exe_ShiftDirection, exe_ALUasrc;
    logic [3:0]  exe_ALUOp;
    logic        exe_flush;
    logic        wb_RegWrite;
    logic [4:0]  wb_RegisterW;
    logic [31:0] wb_WriteData;
    logic [31:0] mem_ALUResult, mem_WriteData, mem_inst;
    logic [4:0]  mem_RegisterW;
    logic        mem_MemRead, mem_MemWrite, mem_MemtoReg, mem_RegWrite, mem_Zero, mem_Overflow;

    int n_checks = 0;
    int n_errors = 0;

    // reference EX/MEM contents
    logic [31:0] m_alu = 0, m_wd = 0, m_inst = 0;
    logic [4:0]  m_w = 0;
    logic        m_mr = 0, m_mw = 0, m_m2r = 0, m_rw = 0, m_z = 0, m_ov = 0;

    always #5 clk = ~clk;

    exe_stage dut (
        .clk(clk), .rst(rst),
        .exe_inst(exe_inst), .exe_RFRD1(exe_RFRD1), .exe_RFRD2(exe_RFRD2), .exe_imm32(exe_imm32),
        .exe_RegisterRd(exe_RegisterRd), .exe_RegisterRs(exe_RegisterRs), .exe_RegisterRt(exe_RegisterRt),
        .exe_RegDst(exe_RegDst), .exe_MemRead(exe_MemRead), .exe_MemtoReg(exe_MemtoReg),
        .exe_MemWrite(exe_MemWrite), .exe_ALUSrc(exe_ALUSrc), .exe_RegWrite(exe_RegWrite),
        .exe_ShiftIndex(exe_ShiftIndex), .exe_ShiftDirection(exe_ShiftDirection),
        .exe_ALUasrc(exe_ALUasrc), .exe_ALUOp(exe_ALUOp), .exe_flush(exe_flush),
        .wb_RegWrite(wb_RegWrite), .wb_RegisterW(wb_RegisterW), .wb_WriteData(wb_WriteData),
        .mem_ALUResult(mem_ALUResult), .mem_WriteData(mem_WriteData), .mem_RegisterW(mem_RegisterW),
        .mem_MemRead(mem_MemRead), .mem_MemWrite(mem_MemWrite), .mem_MemtoReg(mem_MemtoReg),
        .mem_RegWrite(mem_RegWrite), .mem_Zero(mem_Zero), .mem_Overflow(mem_Overflow),
        .mem_inst(mem_inst)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] fwd(input logic [4:0] idx, input logic [31:0] rf);
        if (idx == 0) return rf;
        if (m_rw && !m_mr && m_w == idx) return m_alu;
        if (wb_RegWrite && wb_RegisterW == idx) return wb_WriteData;
        return rf;
    endfunction

    task automatic clear_inputs();
        rst = 0; exe_inst = 0; exe_RFRD1 = 0; exe_RFRD2 = 0; exe_imm32 = 0;
        exe_RegisterRd = 0; exe_RegisterRs = 0; exe_RegisterRt = 0;
        exe_RegDst = 0; exe_MemRead = 0; exe_MemtoReg = 0; exe_MemWrite = 0; exe_ALUSrc = 0;
        exe_RegWrite = 0; exe_ShiftIndex = 0; exe_ShiftDirection = 0; exe_ALUasrc = 0;
        exe_ALUOp = 0; exe_flush = 0; wb_RegWrite = 0; wb_RegisterW = 0; wb_WriteData = 0;
    endtask

    // Apply current inputs for one clock edge, then compare every output with the reference.
    task automatic cycle();
        logic [31:0] fa, fb, a, b, r;
        logic [4:0]  s;
        logic        ov;
        longint      wide;
        fa = fwd(exe_RegisterRs, exe_RFRD1);
        fb = fwd(exe_RegisterRt, exe_RFRD2);
        a  = exe_ALUasrc ? 32'd0 : fa;
        b  = exe_ALUSrc ? exe_imm32 : fb;
        s  = exe_ShiftIndex ? 5'((exe_inst >> 6) % 32) : 5'(a % 32);
        r  = 0; ov = 0;
        case (exe_ALUOp)
            0: begin r = a + b; wide = longint'($signed(a)) + longint'($signed(b));
                     ov = (wide > 64'sd2147483647) || (wide < -64'sd2147483648); end
            1: begin r = a - b; wide = longint'($signed(a)) - longint'($signed(b));
                     ov = (wide > 64'sd2147483647) || (wide < -64'sd2147483648); end
            2: r = a & b;
            3: r = a | b;
            4: r = a ^ b;
            5: r = ~(a | b);
            6: r = (longint'($signed(a)) < longint'($signed(b))) ? 1 : 0;
            7: r = (longint'(a) < longint'(b)) ? 1 : 0;
            8: r = exe_ShiftDirection ? (b >> s) : (b << s);
            9: begin r = b >> s; if (b >= 32'h8000_0000) r = r | ~(32'hFFFF_FFFF >> s); end
            10: r = b * 32'd65536;
            default: r = 0;
        endcase
        @(posedge clk);
        if (rst) begin
            m_alu = 0; m_wd = 0; m_inst = 0; m_w = 0;
            m_mr = 0; m_mw = 0; m_m2r = 0; m_rw = 0; m_z = 0; m_ov = 0;
        end else begin
            m_alu = r; m_wd = fb; m_inst = exe_inst;
            m_w   = exe_RegDst ? exe_RegisterRd : exe_RegisterRt;
            m_z   = (r == 0);
            m_mr  = exe_MemRead  & ~exe_flush;
            m_mw  = exe_MemWrite & ~exe_flush;
            m_m2r = exe_MemtoReg & ~exe_flush;
            m_rw  = exe_RegWrite & ~exe_flush;
            m_ov  = ov & ~exe_flush;
        end
        #1;
        chk("alu", mem_ALUResult, m_alu);
        chk("wdata", mem_WriteData, m_wd);
        chk("inst", mem_inst, m_inst);
        chk("regw", 32'(mem_RegisterW), 32'(m_w));
        chk("ctrl", {28'h0, mem_MemRead, mem_MemWrite, mem_MemtoReg, mem_RegWrite},
                    {28'h0, m_mr, m_mw, m_m2r, m_rw});
        chk("flags", {30'h0, mem_Zero, mem_Overflow}, {30'h0, m_z, m_ov});
        @(negedge clk);
    endtask

    initial begin
        clear_inputs();
        // reset with arbitrary inputs
        rst = 1; exe_inst = 32'hDEAD_BEEF; exe_RFRD1 = 32'h1234; exe_RFRD2 = 32'h5678;
        exe_RegWrite = 1; exe_MemWrite = 1; exe_MemRead = 1; exe_MemtoReg = 1;
        exe_RegisterRt = 5'd9; exe_imm32 = 32'hFFFF;
        cycle();
        chk("rst_alu", mem_ALUResult, 32'h0);
        chk("rst_ctrl", {28'h0, mem_MemRead, mem_MemWrite, mem_MemtoReg, mem_RegWrite}, 32'h0);

        clear_inputs(); exe_RFRD1 = 5; exe_RFRD2 = 7; exe_RegisterRs = 10; exe_RegisterRt = 11;
        cycle();
        chk("post_rst_add", mem_ALUResult, 32'd12);
        chk("post_rst_zero", 32'(mem_Zero), 32'd0);

        // ADD $3=$1+$2 then SUB $4=$3-$1 with stale RF -> MEM forward
        clear_inputs(); exe_RegisterRs = 1; exe_RegisterRt = 2; exe_RFRD1 = 10; exe_RFRD2 = 20;
        exe_RegDst = 1; exe_RegisterRd = 3; exe_RegWrite = 1;
        cycle();
        chk("add_30", mem_ALUResult, 32'd30);
        clear_inputs(); exe_ALUOp = 1; exe_RegisterRs = 3; exe_RegisterRt = 1; exe_RFRD1 = 0;
        exe_RFRD2 = 10; exe_RegDst = 1; exe_RegisterRd = 4; exe_RegWrite = 1;
        cycle();
        chk("fwd_mem", mem_ALUResult, 32'd20);
        // same, with $3 also pending in WB: MEM must win
        clear_inputs(); exe_RegisterRs = 1; exe_RegisterRt = 2; exe_RFRD1 = 10; exe_RFRD2 = 20;
        exe_RegDst = 1; exe_RegisterRd = 3; exe_RegWrite = 1;
        cycle();
        clear_inputs(); exe_ALUOp = 1; exe_RegisterRs = 3; exe_RegisterRt = 1; exe_RFRD2 = 10;
        exe_RegDst = 1; exe_RegisterRd = 4; exe_RegWrite = 1;
        wb_RegWrite = 1; wb_RegisterW = 3; wb_WriteData = 99;
        cycle();
        chk("fwd_mem_beats_wb", mem_ALUResult, 32'd20);

        // WB forward into A; this instr writes $0 so MEM then holds W=0 with a nonzero value
        clear_inputs(); exe_RegisterRs = 5; exe_RegisterRt = 6; exe_RFRD1 = 1; exe_ALUSrc = 1;
        exe_RegWrite = 1; exe_RegDst = 1; exe_RegisterRd = 0;
        wb_RegWrite = 1; wb_RegisterW = 5; wb_WriteData = 32'h55;
        cycle();
        chk("fwd_wb", mem_ALUResult, 32'h55);
        clear_inputs(); exe_RegisterRs = 0; exe_RegisterRt = 0; exe_ALUSrc = 1;
        wb_RegWrite = 1; wb_RegisterW = 0; wb_WriteData = 32'h55;
        cycle();
        chk("no_fwd_r0", mem_ALUResult, 32'h0);
        chk("no_fwd_r0_wd", mem_WriteData, 32'h0);

        // shifts with immediate shift amount 4
        clear_inputs(); exe_ALUOp = 8; exe_RegisterRt = 20; exe_RFRD2 = 32'h8000_0001;
        exe_ShiftIndex = 1; exe_inst = 32'd4 << 6;
        cycle();
        chk("sll4", mem_ALUResult, 32'h0000_0010);
        exe_ShiftDirection = 1;
        cycle();
        chk("srl4", mem_ALUResult, 32'h0800_0000);
        exe_ALUOp = 9;
        cycle();
        chk("sra4", mem_ALUResult, 32'hF800_0000);
        exe_ALUOp = 8; exe_ShiftDirection = 0; exe_ShiftIndex = 0;
        exe_RegisterRs = 21; exe_RFRD1 = 35;
        cycle();
        chk("sll_var3", mem_ALUResult, 32'h0000_0008);

        // flags
        clear_inputs(); exe_RegisterRs = 22; exe_RFRD1 = 32'h7FFF_FFFF; exe_ALUSrc = 1; exe_imm32 = 1;
        cycle();
        chk("ovf_res", mem_ALUResult, 32'h8000_0000);
        chk("ovf_flag", 32'(mem_Overflow), 32'd1);
        clear_inputs(); exe_ALUOp = 1; exe_RegisterRs = 22; exe_RegisterRt = 23;
        exe_RFRD1 = 5; exe_RFRD2 = 5;
        cycle();
        chk("zero_flag", 32'(mem_Zero), 32'd1);
        exe_ALUOp = 6; exe_RFRD1 = 32'hFFFF_FFFF; exe_RFRD2 = 1;
        cycle();
        chk("slt", mem_ALUResult, 32'd1);
        exe_ALUOp = 7;
        cycle();
        chk("sltu", mem_ALUResult, 32'd0);

        // flushed writer is not forwarded
        clear_inputs(); exe_RegWrite = 1; exe_MemWrite = 1; exe_MemRead = 1; exe_MemtoReg = 1;
        exe_RegDst = 1; exe_RegisterRd = 7; exe_RFRD1 = 40; exe_RegisterRs = 24; exe_flush = 1;
        cycle();
        chk("flush_ctrl", {28'h0, mem_MemRead, mem_MemWrite, mem_MemtoReg, mem_RegWrite}, 32'h0);
        clear_inputs(); exe_RegisterRs = 7; exe_RFRD1 = 3; exe_ALUSrc = 1;
        cycle();
        chk("flush_no_fwd", mem_ALUResult, 32'd3);
        // load in MEM matching rs is not forwarded
        clear_inputs(); exe_MemRead = 1; exe_MemtoReg = 1; exe_RegWrite = 1; exe_RegisterRt = 8;
        exe_RegisterRs = 25; exe_RFRD1 = 100; exe_ALUSrc = 1; exe_imm32 = 4;
        cycle();
        chk("load_addr", mem_ALUResult, 32'd104);
        clear_inputs(); exe_RegisterRs = 8; exe_RFRD1 = 1; exe_ALUSrc = 1;
        cycle();
        chk("load_no_fwd", mem_ALUResult, 32'd1);

        // mid-stream reset discards in-flight instruction
        clear_inputs(); exe_RFRD1 = 9; exe_RegWrite = 1; exe_RegisterRt = 2; rst = 1;
        cycle();
        chk("mid_rst", mem_ALUResult, 32'h0);

        // random instructions with small register range to provoke hazards
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 49) == 0);
            exe_inst = $urandom; exe_RFRD1 = $urandom; exe_RFRD2 = $urandom;
            exe_imm32 = ($urandom_range(0, 3) == 0) ? 32'h7FFF_FFFF : $urandom;
            exe_RegisterRd = 5'($urandom_range(0, 3));
            exe_RegisterRs = 5'($urandom_range(0, 3));
            exe_RegisterRt = 5'($urandom_range(0, 3));
            exe_RegDst = 1'($urandom); exe_MemRead = ($urandom_range(0, 3) == 0);
            exe_MemtoReg = 1'($urandom); exe_MemWrite = 1'($urandom);
            exe_ALUSrc = 1'($urandom); exe_RegWrite = 1'($urandom);
            exe_ShiftIndex = 1'($urandom); exe_ShiftDirection = 1'($urandom);
            exe_ALUasrc = ($urandom_range(0, 7) == 0);
            exe_ALUOp = 4'($urandom_range(0, 15));
            exe_flush = ($urandom_range(0, 7) == 0);
            wb_RegWrite = 1'($urandom); wb_RegisterW = 5'($urandom_range(0, 3));
            wb_WriteData = $urandom;
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
